// File: rtl/gbsha_fir_decimator.sv
// Decimating output stage behind the FIR filter.
// Accumulate-and-dump over 2**LOG2_DEC samples with round-half-up averaging,
// saturation to BW_out, and a first-word-fall-through result FIFO with a
// valid/ready read side.
module gbsha_fir_decimator #(
    parameter int BW_in      = 8,
    parameter int LOG2_DEC   = 2,
    parameter int BW_out     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [BW_in-1:0]       y_in,
    input  logic                          y_valid,
    input  logic                          sync_clr,
    output logic signed [BW_out-1:0]      out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow,
    output logic                          saturated
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FW    = AW + 1;
    localparam int ACC_W = BW_in + LOG2_DEC;
    // One guard bit so the rounding term can never wrap the sum
    localparam int SUM_W = ACC_W + 1;
    localparam int PW    = (LOG2_DEC > 0) ? LOG2_DEC : 1;

    localparam logic [PW-1:0]              PH_LAST = PW'((1 << LOG2_DEC) - 1);
    localparam logic signed [SUM_W-1:0]    RND     = SUM_W'((1 << LOG2_DEC) >> 1);
    localparam logic signed [BW_out-1:0]   OUT_MAX = {1'b0, {(BW_out-1){1'b1}}};
    localparam logic signed [BW_out-1:0]   OUT_MIN = {1'b1, {(BW_out-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc;
    logic [PW-1:0]            phase;
    logic signed [SUM_W-1:0]  sum_rnd;
    logic signed [SUM_W-1:0]  avg;
    logic signed [BW_out-1:0] avg_sat;
    logic                     clip;
    logic                     dump;
    logic                     push;
    logic                     pop;

    logic signed [BW_out-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;

    // Dump datapath: final sum, rounded average, clip to output range
    always_comb begin
        sum_rnd = SUM_W'(acc) + SUM_W'(y_in) + RND;
        avg     = sum_rnd >>> LOG2_DEC;
        clip    = 1'b0;
        avg_sat = avg[BW_out-1:0];
        if (avg > SUM_W'(OUT_MAX)) begin
            avg_sat = OUT_MAX;
            clip    = 1'b1;
        end else if (avg < SUM_W'(OUT_MIN)) begin
            avg_sat = OUT_MIN;
            clip    = 1'b1;
        end
    end

    // Handshake / FIFO control decode
    always_comb begin
        dump      = y_valid && !sync_clr && (phase == PH_LAST);
        out_valid = (fill != '0);
        pop       = out_valid && out_ready;
        push      = dump && ((fill < FW'(FIFO_DEPTH)) || pop);
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Accumulator and phase counter; sync_clr discards any coincident sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            phase <= '0;
        end else if (sync_clr) begin
            acc   <= '0;
            phase <= '0;
        end else if (y_valid) begin
            if (phase == PH_LAST) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= acc + ACC_W'(y_in);
                phase <= phase + PW'(1);
            end
        end
    end

    // FIFO pointers, occupancy and sticky status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (push && !pop)
                fill <= fill + FW'(1);
            else if (pop && !push)
                fill <= fill - FW'(1);
            if (dump && !push)
                overflow <= 1'b1;
            if (dump && clip)
                saturated <= 1'b1;
        end
    end

    // FIFO storage; contents are only visible through the occupancy-gated head
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= avg_sat;
    end

endmodule

// File: tb/tb_gbsha_fir_decimator.sv
// Scoreboard bench for gbsha_fir_decimator across three parameter sets:
// cfg0 (D=4, 8-bit out), cfg1 (D=4, 6-bit out), cfg2 (D=1 pass-through).
module tb_gbsha_fir_decimator;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int L  = (g == 2) ? 0 : 2;
        localparam int BO = (g == 1) ? 6 : 8;
        localparam int D  = 1 << L;

        logic                 rst_n = 1'b0;
        logic signed [7:0]    y_in = '0;
        logic                 y_valid = 1'b0;
        logic                 sync_clr = 1'b0;
        logic                 out_ready = 1'b0;
        logic signed [BO-1:0] out_data;
        logic                 out_valid;
        logic [2:0]           fill;
        logic                 overflow;
        logic                 saturated;

        gbsha_fir_decimator #(
            .BW_in(8), .LOG2_DEC(L), .BW_out(BO), .FIFO_DEPTH(DEPTH)
        ) dut (
            .clk(clk), .reset(rst_n), .y_in(y_in), .y_valid(y_valid),
            .sync_clr(sync_clr), .out_data(out_data), .out_valid(out_valid),
            .out_ready(out_ready), .fill(fill), .overflow(overflow),
            .saturated(saturated)
        );

        // Reference model state
        int  exp_q[$];
        int  m_fill = 0;
        int  m_sum = 0;
        int  m_cnt = 0;
        bit  m_ovf = 0;
        bit  m_sat = 0;
        int  last_popped = 0;
        bit  done = 0;

        // Average of D samples: floor((s + D/2) / D), then clip to BO bits
        function automatic int avgf(input int s);
            int t, q, hi, lo;
            t = s + D / 2;
            q = t / D;
            if (t < 0 && (t % D) != 0) q = q - 1;
            hi = (1 << (BO - 1)) - 1;
            lo = -(1 << (BO - 1));
            if (q > hi) begin q = hi; m_sat = 1; end
            if (q < lo) begin q = lo; m_sat = 1; end
            return q;
        endfunction

        task automatic model_edge();
            bit pop_m, dump;
            int w;
            pop_m = (m_fill > 0) && out_ready;
            dump  = 0;
            w     = 0;
            if (sync_clr) begin
                m_sum = 0; m_cnt = 0;
            end else if (y_valid) begin
                m_sum += int'(y_in);
                m_cnt++;
                if (m_cnt == D) begin
                    dump = 1;
                    w = avgf(m_sum);
                    m_sum = 0; m_cnt = 0;
                end
            end
            if (dump) begin
                if (m_fill < DEPTH || pop_m) begin
                    exp_q.push_back(w);
                    if (!pop_m) m_fill++;
                end else begin
                    m_ovf = 1;
                end
            end else if (pop_m) begin
                m_fill--;
            end
        endtask

        task automatic drive(input int y, input bit v, input bit sc, input bit rdy);
            y_in = 8'(y); y_valid = v; sync_clr = sc; out_ready = rdy;
            @(posedge clk);
            model_edge();
            #1;
        endtask

        task automatic do_reset();
            rst_n = 1'b0; y_valid = 1'b0; sync_clr = 1'b0;
            exp_q.delete();
            m_fill = 0; m_sum = 0; m_cnt = 0; m_ovf = 0; m_sat = 0;
            #1;
            chk($sformatf("cfg%0d rst out_valid", g), int'(out_valid), 0);
            chk($sformatf("cfg%0d rst fill", g), int'(fill), 0);
            chk($sformatf("cfg%0d rst out_data", g), int'(out_data), 0);
            chk($sformatf("cfg%0d rst overflow", g), int'(overflow), 0);
            chk($sformatf("cfg%0d rst saturated", g), int'(saturated), 0);
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
        endtask

        task automatic frame(input int v, input bit rdy);
            for (int i = 0; i < D; i++) drive(v, 1, 0, rdy);
        endtask

        task automatic idle(input int n, input bit rdy);
            for (int i = 0; i < n; i++) drive(0, 0, 0, rdy);
        endtask

        // Monitor: compare status every cycle, pop scoreboard on handshake
        always @(negedge clk) begin
            chk($sformatf("cfg%0d fill", g), int'(fill), m_fill);
            chk($sformatf("cfg%0d out_valid", g), int'(out_valid), int'(m_fill > 0));
            chk($sformatf("cfg%0d overflow", g), int'(overflow), int'(m_ovf));
            chk($sformatf("cfg%0d saturated", g), int'(saturated), int'(m_sat));
            if (m_fill == 0)
                chk($sformatf("cfg%0d empty out_data", g), int'(out_data), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("cfg%0d unexpected word", g), int'(out_data), -9999);
                end else begin
                    last_popped = exp_q.pop_front();
                    chk($sformatf("cfg%0d out_data", g), int'(out_data), last_popped);
                end
            end
        end

        initial begin
            do_reset();
            if (g == 0) begin
                drive(10, 1, 0, 1); drive(20, 1, 0, 1);
                drive(30, 1, 0, 1); drive(41, 1, 0, 1);
                idle(2, 1);
                chk("cfg0 t1 word", last_popped, 25);
                drive(-1, 1, 0, 1); drive(-1, 1, 0, 1);
                drive(-1, 1, 0, 1); drive(-2, 1, 0, 1);
                idle(2, 1);
                chk("cfg0 t2 neg word", last_popped, -1);
                frame(-128, 1); idle(2, 1);
                chk("cfg0 t2 min word", last_popped, -128);
                frame(127, 1); idle(2, 1);
                chk("cfg0 t2 max word", last_popped, 127);
                chk("cfg0 t2 no sat", int'(saturated), 0);
                for (int k = 1; k <= 5; k++) frame(k, 0);
                chk("cfg0 t4 fill", int'(fill), 4);
                chk("cfg0 t4 overflow", int'(overflow), 1);
                idle(6, 1);
                chk("cfg0 t4 drained", int'(fill), 0);
                drive(5, 1, 0, 1); drive(5, 1, 0, 1);
                drive(99, 1, 1, 1);
                frame(8, 1); idle(2, 1);
                chk("cfg0 t5 sync_clr word", last_popped, 8);
                drive(50, 1, 0, 1); drive(50, 1, 0, 1);
                do_reset();
                frame(8, 1); idle(2, 1);
                chk("cfg0 t5 reset word", last_popped, 8);
                for (int k = 1; k <= 4; k++) frame(k, 0);
                for (int i = 0; i < D - 1; i++) drive(9, 1, 0, 0);
                drive(9, 1, 0, 1);
                idle(1, 0);
                chk("cfg0 t6 fill", int'(fill), 4);
                chk("cfg0 t6 overflow", int'(overflow), 0);
                idle(6, 1);
            end else if (g == 1) begin
                frame(100, 1); idle(2, 1);
                chk("cfg1 t3 pos sat word", last_popped, 31);
                chk("cfg1 t3 saturated", int'(saturated), 1);
                frame(-100, 1); idle(2, 1);
                chk("cfg1 t3 neg sat word", last_popped, -32);
            end else begin
                drive(-7, 1, 0, 1); drive(12, 1, 0, 1); drive(-128, 1, 0, 1);
                idle(2, 1);
                chk("cfg2 pass-through word", last_popped, -128);
            end
            for (int i = 0; i < 400; i++)
                drive(int'($urandom_range(0, 255)) - 128,
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 1) == 1);
            idle(DEPTH + 3, 1);
            chk($sformatf("cfg%0d scoreboard empty", g), exp_q.size(), 0);
            done = 1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got %0d cycles, expected completion", cyc);
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
